mem_ctrl: RTL

Memory controller that serves the MEM stage's load/store requests on the 8-bit external RAM bus. It accepts one read or write request at a time and performs it as 1, 2 or 4 little-endian byte accesses. Loads are sign- or zero-extended to 32 bits. It reports progress to the MEM stage with `read_busy_o`/`write_busy_o` and a one-cycle `finish_o` pulse.

---
 rtl/mem_ctrl.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/mem_ctrl.sv
// Purpose : MEM-stage load/store controller on an 8-bit RAM bus (1/2/4 little-endian byte accesses).
// Latency : load N bytes -> finish_o at T0+N+2; store N bytes -> finish_o at T0+N+1.
// Backpres: one request at a time, sampled only in IDLE; optional IO stall holds store strobes.
//
// Ports   : clk, rst (async, active high)
//           read_i/read_addr_i          load request (type, byte address)
//           write_i/write_addr_i/write_data_i  store request (type, byte address, data)
//           read_busy_o/write_busy_o/finish_o/read_data_o  status and extended load result
//           mem_din_i/mem_a_o/mem_dout_o/mem_wr_o          external RAM bus
//           io_buffer_full_i            only with MEM_CTRL_IO_STALL_EN
// Macro   : MEM_CTRL_IO_STALL_EN - stalls stores to addr[17:16]=2'b11 while io_buffer_full_i is high.
module mem_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  read_i,
  input  logic [31:0] read_addr_i,
  input  logic [1:0]  write_i,
  input  logic [31:0] write_addr_i,
  input  logic [31:0] write_data_i,
  output logic        read_busy_o,
  output logic        write_busy_o,
  output logic [31:0] read_data_o,
  output logic        finish_o,
  input  logic [7:0]  mem_din_i,
  output logic [31:0] mem_a_o,
  output logic [7:0]  mem_dout_o,
  output logic        mem_wr_o
`ifdef MEM_CTRL_IO_STALL_EN
  ,
  input  logic        io_buffer_full_i
`endif
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t      r_state, w_next;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rbuf;
  logic [2:0]  r_rtype;
  logic [2:0]  r_cnt;    // READ: cycles spent (issue index and receive index+1); WRITE: byte index
  logic [2:0]  r_n;      // transfer size in bytes: 1, 2 or 4

  logic [2:0]  w_n_rd, w_n_wr;
  logic        w_stall;
  logic        w_issue;
  logic [1:0]  w_lane;
  logic [31:0] w_rbuf;
  logic [31:0] w_ext;

  // Size decode; the unused load codes 110/111 fall through to a word.
  always_comb begin
    w_n_rd = 3'd4;
    case (read_i)
      3'b001, 3'b100: w_n_rd = 3'd1;
      3'b010, 3'b101: w_n_rd = 3'd2;
      default:        w_n_rd = 3'd4;
    endcase
    w_n_wr = 3'd4;
    case (write_i)
      2'b01:   w_n_wr = 3'd1;
      2'b10:   w_n_wr = 3'd2;
      default: w_n_wr = 3'd4;
    endcase
  end

`ifdef MEM_CTRL_IO_STALL_EN
  // The IO window is selected by the base address of the store, not addr+k.
  assign w_stall = (r_state == WRITE) && (r_addr[17:16] == 2'b11) && io_buffer_full_i;
`else
  assign w_stall = 1'b0;
`endif

  // In READ the last cycle only collects the final byte, so no address is issued then.
  assign w_issue = (r_state == WRITE) || ((r_state == READ) && (r_cnt < r_n));

  assign read_busy_o  = (r_state == READ);
  assign write_busy_o = (r_state == WRITE);
  assign finish_o     = (r_state == DONE);
  assign mem_a_o      = w_issue ? (r_addr + {29'd0, r_cnt}) : 32'd0;
  assign mem_wr_o     = (r_state == WRITE) && !w_stall;

  always_comb begin
    mem_dout_o = 8'd0;
    if (r_state == WRITE) begin
      case (r_cnt[1:0])
        2'd0:    mem_dout_o = r_wdata[7:0];
        2'd1:    mem_dout_o = r_wdata[15:8];
        2'd2:    mem_dout_o = r_wdata[23:16];
        default: mem_dout_o = r_wdata[31:24];
      endcase
    end
  end

  // RAM data arriving now belongs to the address issued one cycle earlier (lane r_cnt-1).
  always_comb begin
    w_lane = r_cnt[1:0] - 2'd1;
    w_rbuf = r_rbuf;
    case (w_lane)
      2'd0:    w_rbuf[7:0]   = mem_din_i;
      2'd1:    w_rbuf[15:8]  = mem_din_i;
      2'd2:    w_rbuf[23:16] = mem_din_i;
      default: w_rbuf[31:24] = mem_din_i;
    endcase
  end

  always_comb begin
    w_ext = w_rbuf;
    case (r_rtype)
      3'b001:  w_ext = {{24{w_rbuf[7]}},  w_rbuf[7:0]};
      3'b010:  w_ext = {{16{w_rbuf[15]}}, w_rbuf[15:0]};
      3'b100:  w_ext = {24'd0, w_rbuf[7:0]};
      3'b101:  w_ext = {16'd0, w_rbuf[15:0]};
      default: w_ext = w_rbuf;
    endcase
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (write_i != 2'd0)     w_next = WRITE;
        else if (read_i != 3'd0) w_next = READ;
      end
      READ:    if (r_cnt == r_n) w_next = DONE;
      WRITE:   if (!w_stall && (r_cnt == r_n - 3'd1)) w_next = DONE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_addr      <= 32'd0;
      r_wdata     <= 32'd0;
      r_rbuf      <= 32'd0;
      r_rtype     <= 3'd0;
      r_cnt       <= 3'd0;
      r_n         <= 3'd0;
      read_data_o <= 32'd0;
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE: begin
          r_cnt <= 3'd0;
          // A store wins over a simultaneous load; the load is dropped.
          if (write_i != 2'd0) begin
            r_addr  <= write_addr_i;
            r_wdata <= write_data_i;
            r_n     <= w_n_wr;
          end else if (read_i != 3'd0) begin
            r_addr  <= read_addr_i;
            r_rtype <= read_i;
            r_n     <= w_n_rd;
            r_rbuf  <= 32'd0;
          end
        end
        READ: begin
          r_cnt <= r_cnt + 3'd1;
          if (r_cnt != 3'd0) r_rbuf <= w_rbuf;
          if (r_cnt == r_n)  read_data_o <= w_ext;
        end
        WRITE: begin
          if (!w_stall) r_cnt <= r_cnt + 3'd1;
        end
        default: r_cnt <= 3'd0;
      endcase
    end
  end

endmodule
